// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter controller slice.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // busy covers both the counting and the frozen phase of a run
  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/counter_core.sv
// Count register: clear, increment or wrap to zero under control of the FSM.
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             wrap,
  output logic [WIDTH-1:0] count
);

  // clr beats en; wrap only matters on an enabled cycle
  always_ff @(posedge clk) begin
    if (!reset)     count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= wrap ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-control FSM with prescaler and start-time latches around counter_core.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] terminal,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nxt;
  logic               mode_q;
  logic [WIDTH-1:0]   term_q;
  logic [PRE_W-1:0]   pre_lim_q;
  logic [PRE_W-1:0]   pre_q, pre_nxt;
  logic               latch, clr, en, wrap, done_nxt;
  logic               tick, at_term;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .wrap  (wrap),
    .count (count)
  );

  // Next-state decode. The edge that samples pause in RUN still processes
  // its tick, so a coincident terminal tick completes before freezing; a
  // one-shot terminal goes to DONE rather than HOLD.
  always_comb begin
    tick      = (state == ST_RUN) && (pre_q == pre_lim_q);
    at_term   = (count == term_q);
    state_nxt = state;
    pre_nxt   = pre_q;
    latch     = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    wrap      = 1'b0;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      pre_nxt   = '0;
      clr       = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt = ST_RUN;
            latch     = 1'b1;
            clr       = 1'b1;
            pre_nxt   = '0;
          end
        end
        ST_RUN: begin
          state_nxt = pause ? ST_HOLD : ST_RUN;
          if (tick) begin
            pre_nxt = '0;
            if (at_term) begin
              done_nxt = 1'b1;
              if (mode_q) begin
                en   = 1'b1;
                wrap = 1'b1;
              end else begin
                state_nxt = ST_DONE;
              end
            end else begin
              en = 1'b1;
            end
          end else begin
            pre_nxt = pre_q + PRE_W'(1);
          end
        end
        ST_HOLD: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      pre_q <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      pre_q <= pre_nxt;
      done  <= done_nxt;
      busy  <= is_busy(state_nxt);
    end
  end

  // Run configuration captured on the start edge only
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= 1'b0;
      term_q    <= '0;
      pre_lim_q <= '0;
    end else if (latch) begin
      mode_q    <= mode;
      term_q    <= terminal;
      pre_lim_q <= prescale;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl (WIDTH=4, PRE_W=4).
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic       clk;
  logic       reset, start, stop, pause, mode;
  logic [3:0] terminal, prescale;
  logic [3:0] count;
  logic       busy, done;

  int tests = 0;
  int fails = 0;

  counter_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .terminal (terminal),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int c, input int b, input int d);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " busy"},  32'(busy),  32'(b));
    chk({tag, " done"},  32'(done),  32'(d));
  endtask

  initial begin
    int dn;
    reset = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0;
    mode = 1'b0; terminal = 4'd0; prescale = 4'd0;

    // reset held with start high
    step(); outs("rst0", 0, 0, 0);
    step(); outs("rst1", 0, 0, 0);
    reset = 1'b1; start = 1'b0;
    step(); outs("idle", 0, 0, 0);

    // one-shot, terminal 5, prescale 0
    prescale = 4'd0; terminal = 4'd5; mode = 1'b0; start = 1'b1;
    step(); outs("os entry", 0, 1, 0);
    start = 1'b0; terminal = 4'd9;
    dn = 0;
    for (int k = 1; k <= 5; k++) begin
      step(); outs($sformatf("os k%0d", k), k, 1, 0);
    end
    step(); outs("os term", 5, 0, 1);
    chk("os state", 32'(dut.state), 32'(ST_DONE));
    step(); outs("os hold", 5, 0, 0);
    step(); outs("os hold2", 5, 0, 0);

    // periodic from DONE, terminal 3, prescale 2; start pulse mid-run ignored
    prescale = 4'd2; terminal = 4'd3; mode = 1'b1; start = 1'b1;
    step(); outs("per entry", 0, 1, 0);
    start = 1'b0; terminal = 4'd1; prescale = 4'd0; mode = 1'b0;
    dn = 0;
    for (int k = 1; k <= 24; k++) begin
      start = (k == 5);
      step();
      chk($sformatf("per count k%0d", k), 32'(count), 32'((k / 3) % 4));
      chk($sformatf("per done k%0d", k), 32'(done), 32'(k % 12 == 0));
      if (done) dn++;
    end
    start = 1'b0;
    chk("per dones", 32'(dn), 32'd2);
    stop = 1'b1;
    step(); outs("per stop", 0, 0, 0);
    stop = 1'b0;

    // pause for 4 cycles at count 2, prescale 1
    prescale = 4'd1; terminal = 4'd9; mode = 1'b0; start = 1'b1;
    step(); outs("pz entry", 0, 1, 0);
    start = 1'b0;
    step(); step(); step();
    step(); outs("pz k4", 2, 1, 0);
    pause = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      step(); outs($sformatf("pz hold k%0d", k), 2, 1, 0);
    end
    chk("pz state", 32'(dut.state), 32'(ST_HOLD));
    pause = 1'b0;
    step(); outs("pz resume", 2, 1, 0);
    step(); outs("pz phase", 3, 1, 0);
    stop = 1'b1;
    step(); outs("pz stop", 0, 0, 0);
    stop = 1'b0;

    // stop + start coincident with terminal tick
    prescale = 4'd0; terminal = 4'd2; mode = 1'b0; start = 1'b1;
    step(); outs("st entry", 0, 1, 0);
    start = 1'b0;
    step(); outs("st k1", 1, 1, 0);
    step(); outs("st k2", 2, 1, 0);
    stop = 1'b1; start = 1'b1;
    step(); outs("st abort", 0, 0, 0);
    chk("st state", 32'(dut.state), 32'(ST_IDLE));
    stop = 1'b0; start = 1'b0;
    step(); outs("st after", 0, 0, 0);

    // terminal 15 periodic: full range then single wrap
    prescale = 4'd0; terminal = 4'd15; mode = 1'b1; start = 1'b1;
    step(); outs("t15 entry", 0, 1, 0);
    start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("t15 count k%0d", k), 32'(count), 32'(k % 16));
      if (done) dn++;
    end
    chk("t15 dones", 32'(dn), 32'd1);
    stop = 1'b1;
    step(); outs("t15 stop", 0, 0, 0);
    stop = 1'b0;

    // terminal 0 periodic: done every tick, count stays 0
    prescale = 4'd0; terminal = 4'd0; mode = 1'b1; start = 1'b1;
    step(); outs("t0 entry", 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(); outs($sformatf("t0 k%0d", k), 0, 1, 1);
    end
    // reset mid-run drops the pending done
    reset = 1'b0;
    step(); outs("t0 reset", 0, 0, 0);
    reset = 1'b1;
    step(); outs("t0 idle", 0, 0, 0);

    // periodic terminal tick coincident with pause: wrap, done, then HOLD
    prescale = 4'd0; terminal = 4'd1; mode = 1'b1; start = 1'b1;
    step(); outs("pt entry", 0, 1, 0);
    start = 1'b0;
    step(); outs("pt k1", 1, 1, 0);
    pause = 1'b1;
    step(); outs("pt term", 0, 1, 1);
    chk("pt state", 32'(dut.state), 32'(ST_HOLD));
    step(); outs("pt hold", 0, 1, 0);
    pause = 1'b0;
    stop = 1'b1;
    step(); outs("pt stop", 0, 0, 0);
    stop = 1'b0;

    // one-shot terminal tick coincident with pause goes to DONE
    prescale = 4'd0; terminal = 4'd1; mode = 1'b0; start = 1'b1;
    step(); outs("po entry", 0, 1, 0);
    start = 1'b0;
    step(); outs("po k1", 1, 1, 0);
    pause = 1'b1;
    step(); outs("po term", 1, 0, 1);
    chk("po state", 32'(dut.state), 32'(ST_DONE));
    pause = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 The block SHALL have parameter PRE_W, default 4: prescaler width in bits.
REQ-003 clk  input  1  The only clock. All state SHALL update on its rising edge.
REQ-004 reset  input  1  Reset. It SHALL be synchronous and active-low.
REQ-005 start  input  1  Arms a run. Sampled only in IDLE or DONE.
REQ-006 stop  input  1  Aborts to IDLE. Highest priority.
REQ-007 pause  input  1  Level. Freezes the run while high.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic. Latched on start.
REQ-009 terminal  input  WIDTH  Terminal count. Latched on start.
REQ-010 prescale  input  PRE_W  Tick divider. One tick every prescale+1 cycles. Latched on start.
REQ-011 count  output  WIDTH  Current count value.
REQ-012 busy  output  1  High in RUN or HOLD.
REQ-013 done  output  1  One-cycle pulse when the terminal count is reached.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, HOLD and DONE.
REQ-015 In IDLE, start=1 SHALL cause the following on the next edge:
- move to RUN;
- latch mode, terminal and prescale;
- set count to 0 and the prescaler to 0.
REQ-016 In RUN, the prescaler SHALL increment every cycle. When it equals the latched prescale it SHALL generate a tick and wrap to 0.
REQ-017 With prescale=0, a tick SHALL occur on every cycle, so count=1 one edge after the RUN entry edge.
REQ-018 On a tick with count != terminal, count SHALL increment by 1.
REQ-019 On a tick with count == terminal and mode=0, the FSM SHALL go to DONE with count held at terminal and done=1 for that one cycle.
REQ-020 On a tick with count == terminal and mode=1, count SHALL wrap to 0, done=1 for one cycle, and the FSM SHALL stay in RUN.
REQ-021 With terminal=0, every tick SHALL pulse done and count SHALL remain 0.
REQ-022 With terminal = all ones, count SHALL reach 2^WIDTH-1 without unsigned overflow before done. Count SHALL never wrap through anything other than the terminal rule.
REQ-023 pause=1 in RUN SHALL move the FSM to HOLD on the next edge. Count and prescaler SHALL freeze and no tick SHALL occur.
REQ-024 pause=0 in HOLD SHALL return the FSM to RUN on the next edge, resuming from the frozen prescaler value.
REQ-025 In DONE, count SHALL hold at terminal. start=1 SHALL re-latch the inputs and enter RUN as in REQ-015.
REQ-026 start SHALL be ignored in RUN and HOLD. Latched values SHALL be unaffected by input changes after the start edge.
REQ-027 stop=1 in any state SHALL, on the next edge:
- move to IDLE;
- set count=0;
- suppress done.
stop SHALL override start, pause and any coincident tick.
REQ-028 A simultaneous pause and terminal tick in RUN SHALL complete the terminal action of REQ-019/REQ-020 first. The next state SHALL be HOLD in periodic mode and DONE in one-shot mode.
REQ-029 All outputs SHALL be registered. done SHALL be coincident with the cycle in which the post-terminal count value is visible.

Reset
REQ-030 reset=0 sampled on a clock edge SHALL set:
- state=IDLE;
- count=0;
- prescaler=0;
- busy=0;
- done=0;
- all latched registers=0.
REQ-031 Reset SHALL take priority over stop and start.
REQ-032 Reset asserted mid-run SHALL abort without a done pulse.

Structure
REQ-033 The shared package counter_ctrl_pkg SHALL hold the state enum and the default WIDTH/PRE_W constants.
REQ-034 The count register SHALL live in one sub-module, counter_core, with ports clk, reset, clr, en, wrap and count. counter_ctrl SHALL hold the FSM, the prescaler and the latches.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Reset: reset=0 for 2 cycles with start=1 -> count=0, busy=0, done=0 throughout.
- One-shot: prescale=0, terminal=5, mode=0, start -> count 1..5 on successive edges; done=1 exactly once with count=5; FSM in DONE; busy=0; count holds 5.
- Periodic with prescaler: prescale=2, terminal=3, mode=1 -> count increments every 3 cycles, sequence 0,1,2,3,0; done pulses every 12 cycles.
- Pause: pause high for 4 cycles at count=2, prescale=1 -> count stays 2, busy stays 1; resumes with remaining prescaler phase intact.
- Stop with coincident terminal tick and start: terminal=2, prescale=0; stop and start both high on the cycle count reaches 2 -> IDLE, count=0, no done.
- Boundary: terminal=15 and terminal=0 in mode=1 -> 15 wraps to 0 with one done; terminal=0 gives done on every tick with count=0.
